seq_restoring_div: RTL

Sequential restoring divider that is the inverse of the 16x16 array multiplier. It takes a 2W-bit dividend, such as a multiplier product, and a W-bit divisor. It returns a W-bit quotient and a W-bit remainder after W iteration cycles. It sits beside the multiplier in the arithmetic datapath and uses a valid/ready handshake on both input and output.

---
 rtl/seq_restoring_div_pkg.sv | 23 ++
 rtl/seq_restoring_div_if.sv | 27 ++
 rtl/seq_restoring_div_step.sv | 25 ++
 rtl/seq_restoring_div.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Optional macro DIV_SIGNED_EN adds the FIXUP state for two's complement operation.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
`ifdef DIV_SIGNED_EN
        ,
        FIXUP
`endif
    } div_state_t;

    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W_DEFAULT = div_cnt_w(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/seq_restoring_div_if.sv
// Operand/result handshake bundle between a requester (master) and the divider (slave).
interface seq_restoring_div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] dividend;
    logic [WIDTH-1:0]   divisor;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic               div_by_zero;
    logic               overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_restoring_div_step.sv
// One combinational restoring step: shift {R,Q} left, subtract divisor when it fits.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] r_sh;

    always_comb begin
        r_sh   = {r, q[WIDTH-1]};
        q_next = {q[WIDTH-2:0], 1'b0};
        r_next = r_sh[WIDTH-1:0];
        // R < divisor before the shift, so the difference always fits in WIDTH bits
        if (r_sh >= {1'b0, divisor}) begin
            r_next    = r_sh[WIDTH-1:0] - divisor;
            q_next[0] = 1'b1;
        end
    end
endmodule

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor in W iteration cycles.
// Define DIV_SIGNED_EN for two's complement operands with an extra sign fix-up cycle.
module seq_restoring_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_restoring_div_if.slave  bus
);
    localparam int W     = WIDTH;
    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_t       state_q, state_nx;
    logic [W-1:0]     r_q, r_nx, q_q, q_nx, dsr_q, dsr_nx;
    logic [W-1:0]     quot_q, quot_nx, rem_q, rem_nx;
    logic             dbz_q, dbz_nx, ovf_q, ovf_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [W-1:0]     step_r, step_q;
    logic [2*W-1:0]   dvd_mag;
    logic [W-1:0]     dsr_mag;
`ifdef DIV_SIGNED_EN
    logic             q_neg_q, q_neg_nx, r_neg_q, r_neg_nx;
`endif

    div_step #(.WIDTH(W)) u_step (
        .r       (r_q),
        .q       (q_q),
        .divisor (dsr_q),
        .r_next  (step_r),
        .q_next  (step_q)
    );

`ifdef DIV_SIGNED_EN
    assign dvd_mag = bus.dividend[2*W-1] ? (~bus.dividend + (2*W)'(1)) : bus.dividend;
    assign dsr_mag = bus.divisor[W-1]    ? (~bus.divisor  + W'(1))     : bus.divisor;
`else
    assign dvd_mag = bus.dividend;
    assign dsr_mag = bus.divisor;
`endif

    always_comb begin
        state_nx = state_q;
        r_nx     = r_q;
        q_nx     = q_q;
        dsr_nx   = dsr_q;
        quot_nx  = quot_q;
        rem_nx   = rem_q;
        dbz_nx   = dbz_q;
        ovf_nx   = ovf_q;
        cnt_nx   = cnt_q;
`ifdef DIV_SIGNED_EN
        q_neg_nx = q_neg_q;
        r_neg_nx = r_neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dsr_nx = dsr_mag;
`ifdef DIV_SIGNED_EN
                    q_neg_nx = bus.dividend[2*W-1] ^ bus.divisor[W-1];
                    r_neg_nx = bus.dividend[2*W-1];
`endif
                    if (bus.divisor == '0) begin
                        state_nx = DONE;
                        dbz_nx   = 1'b1;
                        ovf_nx   = 1'b0;
                        quot_nx  = '1;
                        rem_nx   = bus.dividend[W-1:0];
                    end else if (dvd_mag[2*W-1:W] >= dsr_mag) begin
                        state_nx = DONE;
                        dbz_nx   = 1'b0;
                        ovf_nx   = 1'b1;
                        quot_nx  = '1;
                        rem_nx   = '0;
                    end else begin
                        state_nx = RUN;
                        r_nx     = dvd_mag[2*W-1:W];
                        q_nx     = dvd_mag[W-1:0];
                        cnt_nx   = '0;
                    end
                end
            end
            RUN: begin
                r_nx   = step_r;
                q_nx   = step_q;
                cnt_nx = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
`ifdef DIV_SIGNED_EN
                    state_nx = FIXUP;
`else
                    state_nx = DONE;
                    quot_nx  = step_q;
                    rem_nx   = step_r;
                    dbz_nx   = 1'b0;
                    ovf_nx   = 1'b0;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            FIXUP: begin
                // Negative quotients may reach magnitude 2^(W-1); positive ones may not
                state_nx = DONE;
                dbz_nx   = 1'b0;
                ovf_nx   = q_neg_q ? (q_q > {1'b1, {(W-1){1'b0}}}) : q_q[W-1];
                if (ovf_nx) begin
                    quot_nx = '1;
                    rem_nx  = '0;
                end else begin
                    quot_nx = q_neg_q ? (~q_q + W'(1)) : q_q;
                    rem_nx  = r_neg_q ? (~r_q + W'(1)) : r_q;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dsr_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_nx;
            r_q     <= r_nx;
            q_q     <= q_nx;
            dsr_q   <= dsr_nx;
            quot_q  <= quot_nx;
            rem_q   <= rem_nx;
            dbz_q   <= dbz_nx;
            ovf_q   <= ovf_nx;
            cnt_q   <= cnt_nx;
`ifdef DIV_SIGNED_EN
            q_neg_q <= q_neg_nx;
            r_neg_q <= r_neg_nx;
`endif
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule
